data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder side of the pipeline's MEM-stage data-memory interface: services load/store requests from the EX/MEM register with a configurable multi-cycle latency.
- Holds the word-addressed data store and asserts Stall to freeze the pipeline while an access is outstanding.
- Returns read data with a one-cycle RespValid pulse timed for capture by MEM/WB.
- Sits between ex_mem and mem_wb, in place of a zero-latency data memory.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 10, word-index width; store depth is 2**ADDR_W words.
- LATENCY, 2, cycles an accepted access spends in BUSY; legal range 1..15.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- ReqAddr  input  32  byte address, from ex_memALUResult.
- ReqWData  input  DATA_W  store data, from ex_memReadData2.
- ReqRead  input  1  load request, from ex_memMemRead.
- ReqWrite  input  1  store request, from ex_memMemWrite.
- ReadData  output  DATA_W  load result; valid only while RespValid=1.
- RespValid  output  1  one-cycle completion pulse (loads and stores).
- Stall  output  1  freeze PC, if_id, id_ex and ex_mem while high.
- AlignErr  output  1  pulses with RespValid when ReqAddr[1:0] != 0.

Behaviour:
- Clocking and reset: one clock (Clk); reset Rst is synchronous, active-high.
- Reset values: state IDLE, counter 0, ReadData 0, RespValid 0, AlignErr 0, captured addr/data 0. Stall is 0 in the cycle after reset, unless a request is present.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If ReqRead|ReqWrite is high, capture ReqAddr, ReqWData and the op; load counter = LATENCY-1; go to BUSY.
  - Stall is combinational: Stall = (IDLE & (ReqRead|ReqWrite)) | BUSY, so the pipeline holds in the request's first cycle.
- BUSY:
  - If counter != 0, decrement and stay.
  - If counter == 0, perform the access at this edge and go to RESP.
  - Load: ReadData <= mem[idx].
  - Store: mem[idx] <= wdata; ReadData <= 0.
- RESP:
  - RespValid=1, Stall=0, AlignErr valid; go to IDLE unconditionally.
  - The request still visible in RESP is the one just serviced and is never re-accepted.
- Outputs: ReadData and AlignErr hold their values only during RESP and return to 0 in IDLE.
- Timing: request first presented in cycle C0 → Stall high C0..C_LATENCY → RespValid in C_(LATENCY+1). Total occupancy is LATENCY+2 cycles per access; no back-to-back overlap.
- Address mapping: idx = captured addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2**(ADDR_W+2).
- Misaligned access (addr[1:0] != 0): no store write; load returns ReadData 0; AlignErr=1 in RESP; timing unchanged.
- ReqRead and ReqWrite both high: treated as a store; ReadData 0.
- Request inputs changing during BUSY: ignored, because the captured copies are used.
- Reset in BUSY: pending store discarded (never written); state IDLE; no RespValid.
- Reset in RESP: RespValid forced 0 the following cycle.
- Store contents: not cleared by Rst; zero at time 0.
- A load immediately following a store to the same word returns the new data. Accesses are strictly sequential, so no forwarding is needed.

Decomposition:
- Shared package (pipeline_pkg):
  - state encoding constants IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - WORD_W=32;
  - BYTE_OFFSET_BITS=2.
- One natural sub-module: dm_word_array, a single-port synchronous array with write enable and registered read, parameterised DATA_W/ADDR_W.
- data_mem_responder holds the FSM, latency counter, capture registers and error logic.

Test Plan:
- Reset, then store: Rst for 2 cycles; then ReqWrite=1, ReqAddr=0x10, ReqWData=0xDEADBEEF, LATENCY=2 → Stall high 3 cycles; RespValid pulse in cycle 4; AlignErr=0.
- Load-after-store: ReqRead=1, ReqAddr=0x10 → RespValid with ReadData=0xDEADBEEF exactly 3 cycles after the request appears; Stall low in the RespValid cycle.
- Misaligned store: ReqWrite=1, ReqAddr=0x13, data 0x12345678 → AlignErr=1 with RespValid. A subsequent load of 0x10 still returns 0xDEADBEEF.
- Wrap-around (ADDR_W=10): store 0xA5A5A5A5 to 0x1004, then load 0x0004 → ReadData=0xA5A5A5A5.
- Reset mid-access: store 0x0BADF00D to 0x20; assert Rst in the second BUSY cycle → no RespValid; Stall 0 after reset. A load of 0x20 then returns the prior value 0x00000000.
- Request held through RESP: keep ReqRead=1 on 0x10 across the RESP cycle → exactly one RespValid per request edge sequence. The next access starts in IDLE on the following cycle with Stall high again.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg                                                         |
// | Shared constants and types for the MEM-stage data-memory responder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipeline_pkg;

    localparam int WORD_W           = 32;
    localparam int BYTE_OFFSET_BITS = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e                     op;
        logic [BYTE_OFFSET_BITS-1:0] offset;
    } req_attr_t;

    function automatic logic is_misaligned(input logic [BYTE_OFFSET_BITS-1:0] offset);
        return offset != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_word_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_word_array                                                        |
// | Single-port word store with write enable and registered read.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dm_word_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int c_depth = 1 << ADDR_W;

    // Contents start at zero and are deliberately untouched by reset.
    logic [DATA_W-1:0] r_mem [c_depth] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder                                                   |
// | Multi-cycle MEM-stage data memory: stalls the pipeline while busy.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_mem_responder
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [WORD_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    input  logic              ReqRead,
    input  logic              ReqWrite,
    output logic [DATA_W-1:0] ReadData,
    output logic              RespValid,
    output logic              Stall,
    output logic              AlignErr
);

    localparam int               c_cnt_w      = 4;
    localparam logic [c_cnt_w-1:0] c_count_init = c_cnt_w'(LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_count_one  = c_cnt_w'(1);

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_count;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_wdata;
    req_attr_t           r_attr;

    logic                w_req;
    logic                w_access;
    logic                w_misaligned;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_req        = ReqRead | ReqWrite;
    assign w_access     = (r_state == BUSY) && (r_count == '0);
    assign w_misaligned = is_misaligned(r_attr.offset);

    // Rst gates the write so a store caught by reset in its final BUSY cycle never lands.
    assign w_wr_en = w_access && (r_attr.op == OP_STORE) && !w_misaligned && !Rst;
    assign w_rd_en = w_access && (r_attr.op == OP_LOAD)  && !w_misaligned;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_attr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx       <= ReqAddr[ADDR_W+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
                        r_attr.offset <= ReqAddr[BYTE_OFFSET_BITS-1:0];
                        r_attr.op   <= ReqWrite ? OP_STORE : OP_LOAD;
                        r_wdata     <= ReqWData;
                        r_count     <= c_count_init;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_count != '0) begin
                        r_count <= r_count - c_count_one;
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dm_word_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_word_array (
        .clk     (Clk),
        .wr_en   (w_wr_en),
        .rd_en   (w_rd_en),
        .addr    (r_idx),
        .wr_data (r_wdata),
        .rd_data (w_rd_data)
    );

    assign Stall     = ((r_state == IDLE) && w_req) || (r_state == BUSY);
    assign RespValid = (r_state == RESP);
    assign AlignErr  = (r_state == RESP) && w_misaligned;
    assign ReadData  = ((r_state == RESP) && (r_attr.op == OP_LOAD) && !w_misaligned)
                       ? w_rd_data : '0;

    // Address bits above the word index wrap by design.
    generate
        if (ADDR_W + BYTE_OFFSET_BITS < WORD_W) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^ReqAddr[WORD_W-1:ADDR_W+BYTE_OFFSET_BITS];
        end
    endgenerate

endmodule
`default_nettype wire
